// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default width for the ALU
// command responder and its combinational core.
package alu_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_NOT   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NAND  = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_XNOR  = 4'b0110;
   localparam logic [3:0] OP_ADD   = 4'b1000;
   localparam logic [3:0] OP_SUB   = 4'b1001;
   localparam logic [3:0] OP_SHR   = 4'b1010;
   localparam logic [3:0] OP_SHL   = 4'b1011;
   localparam logic [3:0] OP_CLEAR = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opcode and operands to result plus flags.
// Undefined opcodes give a zero result with err set.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             err
);

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   always_comb begin
      is_sub   = (op == OP_SUB);
      b_eff    = is_sub ? ~b : b;
      sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      err      = 1'b0;
      unique case (op)
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_NOT:   result = ~a;
         OP_XOR:   result = a ^ b;
         OP_NAND:  result = ~(a & b);
         OP_NOR:   result = ~(a | b);
         OP_XNOR:  result = ~(a ^ b);
         OP_ADD, OP_SUB: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHR:   result = a >> 1;
         OP_SHL:   result = a << 1;
         OP_CLEAR: result = '0;
         default:  err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_cmd_responder.sv
// Flow-controlled ALU front end: accept a command, execute it into
// the accumulator, then hold the tagged response until consumed.
module alu_cmd_responder
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] core_res;
   logic             core_carry;
   logic             core_ovf;
   logic             core_err;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .result   (core_res),
      .carry    (core_carry),
      .overflow (core_ovf),
      .err      (core_err)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      tag_d   = tag_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_opcode;
               a_d     = cmd_a;
               b_d     = cmd_b;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            acc_d   = core_res;
            carry_d = core_carry;
            ovf_d   = core_ovf;
            err_d   = core_err;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               tag_d   = tag_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // handshake outputs are registered copies of the next state
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_RESP);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         tag_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         tag_q   <= tag_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign cmd_ready    = ready_q;
   assign rsp_valid    = valid_q;
   assign rsp_result   = acc_q;
   assign rsp_carry    = carry_q;
   assign rsp_overflow = ovf_q;
   assign rsp_err      = err_q;
   assign rsp_tag      = tag_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed plus randomized checks of alu_cmd_responder against an
// arithmetic reference model of the opcode table.
module tb_alu_cmd_responder;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_overflow;
   logic        rsp_err;
   logic [3:0]  rsp_tag;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int exp_tag = 0;

   alu_cmd_responder #(.WIDTH(16), .TAG_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err),
      .rsp_tag      (rsp_tag),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: opcode table evaluated with plain integer arithmetic
   function automatic void model(input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c,
                                 output logic v, output logic e);
      int sa, sb, s;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = 16'h0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (op)
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'h2: r = ~a;
         4'h3: r = a ^ b;
         4'h4: r = ~(a & b);
         4'h5: r = ~(a | b);
         4'h6: r = ~(a ^ b);
         4'h8: begin
            r = a + b;
            c = (int'(a) + int'(b)) > 65535;
            s = sa + sb;
            v = (s > 32767) || (s < -32768);
         end
         4'h9: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
            v = (s > 32767) || (s < -32768);
         end
         4'hA: r = a >> 1;
         4'hB: r = a << 1;
         4'hF: r = 16'h0;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic do_cmd(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int hold,
                         input bit pend);
      logic [15:0] er;
      logic ec, ev, ee;
      int n;
      model(op, a, b, er, ec, ev, ee);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      rsp_ready  = (hold == 0);
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      @(negedge clk);
      cmd_valid = pend;
      cmd_opcode = pend ? 4'hF : op;
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_result", 32'(rsp_result), 32'(er));
      chk("rsp_carry", 32'(rsp_carry), 32'(ec));
      chk("rsp_overflow", 32'(rsp_overflow), 32'(ev));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_result", 32'(rsp_result), 32'(er));
         chk("hold_tag", 32'(rsp_tag), 32'(exp_tag));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      exp_tag = (exp_tag + 1) % 16;
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] rop;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_opcode = 4'h0;
      cmd_a = 16'h0;
      cmd_b = 16'h0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result", 32'(rsp_result), 32'd0);
      chk("rst_flags", 32'({rsp_carry, rsp_overflow, rsp_err}), 32'd0);
      chk("rst_tag", 32'(rsp_tag), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      do_cmd(4'h8, 16'h0002, 16'h0003, 0, 1'b0);
      do_cmd(4'h9, 16'h0002, 16'h0003, 0, 1'b0);
      do_cmd(4'h8, 16'h7FFF, 16'h0001, 0, 1'b0);
      do_cmd(4'h8, 16'hFFFF, 16'h0001, 0, 1'b0);
      do_cmd(4'h0, 16'hC001, 16'h8001, 5, 1'b1);
      do_cmd(4'h8, 16'h0002, 16'h0003, 0, 1'b0);
      do_cmd(4'h7, 16'h1234, 16'h5678, 0, 1'b0);
      do_cmd(4'hF, 16'hABCD, 16'h1111, 0, 1'b0);

      // reset while a SHL is executing
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opcode = 4'hB;
      cmd_a      = 16'h0080;
      cmd_b      = 16'h0000;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_result", 32'(rsp_result), 32'd0);
      chk("mid_rst_tag", 32'(rsp_tag), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_tag = 0;
      do_cmd(4'hA, 16'h0008, 16'hFFFF, 0, 1'b0);

      for (int k = 0; k < 17; k++)
         do_cmd(4'h8, 16'(k), 16'(k * 3), 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         rop = 4'($urandom_range(0, 15));
         do_cmd(rop, 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 2)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
